// File: rtl/vscale_src_a_merge_ctrl.sv
// Folds the captured DOM shares of rs1 into one unmasked source-A operand, one share per cycle.
// Optional macro VSCALE_MERGE_CLEAR_EN adds a CLEAR cycle that scrubs all share state after use.
module vscale_src_a_merge_ctrl #(
  parameter int DWIDTH = 32,
  parameter int SHARES = 2,
  parameter int SRC_A_SEL_WIDTH = 1,
  parameter logic [SRC_A_SEL_WIDTH-1:0] SRC_A_PC = SRC_A_SEL_WIDTH'(1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [SRC_A_SEL_WIDTH-1:0] src_a_sel,
  input  logic [DWIDTH*SHARES-1:0]   rs1_data_shares,
  input  logic                       ex_ack,
  input  logic                       kill,
  output logic                       stall_merge,
  output logic                       merged_valid,
  output logic [DWIDTH-1:0]          rs1_data_merged
);

  localparam int CW = $clog2(SHARES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(SHARES - 1);

`ifdef VSCALE_MERGE_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCUM, DONE, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`endif

  state_t                     state_q, state_d;
  logic [DWIDTH-1:0]          acc_q, acc_d;
  logic [DWIDTH*SHARES-1:0]   cap_q, cap_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DWIDTH-1:0]          cur_share;
  logic                       need_merge;

  assign need_merge      = req_valid && (src_a_sel != SRC_A_PC);
  assign stall_merge     = need_merge && (state_q != DONE);
  assign merged_valid    = (state_q == DONE);
  assign rs1_data_merged = acc_q;

  // Constant-index mux keeps the share select free of variable part-selects.
  always_comb begin
    cur_share = '0;
    for (int i = 0; i < SHARES; i++) begin
      if (cnt_q == CW'(i)) cur_share = cap_q[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (need_merge) begin
          cap_d   = rs1_data_shares;
          acc_d   = rs1_data_shares[DWIDTH-1:0];
          cnt_d   = CW'(1);
          state_d = (SHARES > 1) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        acc_d = acc_q ^ cur_share;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (ex_ack) begin
`ifdef VSCALE_MERGE_CLEAR_EN
          // Scrub on entry so the CLEAR cycle already exposes no share data.
          acc_d   = '0;
          cap_d   = '0;
          cnt_d   = '0;
          state_d = CLEAR;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef VSCALE_MERGE_CLEAR_EN
      CLEAR: begin
        acc_d   = '0;
        cap_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // A flush discards everything and beats both ex_ack and a new request.
    if (kill) begin
      acc_d   = '0;
      cap_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vscale_src_a_merge_ctrl.sv
// Checks two instances (SHARES=2 and SHARES=3) against a countdown/XOR reference model.
// Honours VSCALE_MERGE_CLEAR_EN when the design is built with it.
module tb_vscale_src_a_merge_ctrl;

  localparam int DW = 32;
  localparam logic [0:0] RS1 = 1'b0;
  localparam logic [0:0] PC  = 1'b1;
`ifdef VSCALE_MERGE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, req_valid, ex_ack, kill;
  logic [0:0]      src_a_sel;
  logic [3*DW-1:0] shares;
  logic            stall2, valid2, stall3, valid3;
  logic [DW-1:0]   merged2, merged3;

  vscale_src_a_merge_ctrl #(.DWIDTH(DW), .SHARES(2), .SRC_A_SEL_WIDTH(1), .SRC_A_PC(PC)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .src_a_sel(src_a_sel),
    .rs1_data_shares(shares[2*DW-1:0]), .ex_ack(ex_ack), .kill(kill),
    .stall_merge(stall2), .merged_valid(valid2), .rs1_data_merged(merged2));

  vscale_src_a_merge_ctrl #(.DWIDTH(DW), .SHARES(3), .SRC_A_SEL_WIDTH(1), .SRC_A_PC(PC)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .src_a_sel(src_a_sel),
    .rs1_data_shares(shares), .ex_ack(ex_ack), .kill(kill),
    .stall_merge(stall3), .merged_valid(valid3), .rs1_data_merged(merged3));

  // Model phases: 0 idle, 1 busy (counting down), 2 result held, 3 scrubbing
  int            n_sh [2] = '{2, 3};
  int            ph   [2];
  int            left [2];
  logic [DW-1:0] res  [2];
  bit            zero [2];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit needNow();
    return req_valid && (src_a_sel != PC);
  endfunction

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      if (reset || kill) begin
        ph[k]   = 0;
        zero[k] = 1'b1;
      end else begin
        case (ph[k])
          0: if (needNow()) begin
            res[k] = '0;
            for (int i = 0; i < n_sh[k]; i++) res[k] ^= shares[i*DW +: DW];
            zero[k] = 1'b0;
            left[k] = n_sh[k] - 1;
            ph[k]   = (left[k] > 0) ? 1 : 2;
          end
          1: begin
            left[k]--;
            if (left[k] == 0) ph[k] = 2;
          end
          2: if (ex_ack) begin
            if (CLR_EN) begin
              ph[k]   = 3;
              zero[k] = 1'b1;
            end else begin
              ph[k] = 0;
            end
          end
          default: ph[k] = 0;
        endcase
      end
    end
  endtask

  task automatic checkAll();
    logic          gs, gv;
    logic [DW-1:0] gd;
    for (int k = 0; k < 2; k++) begin
      gs = (k == 0) ? stall2  : stall3;
      gv = (k == 0) ? valid2  : valid3;
      gd = (k == 0) ? merged2 : merged3;
      checkOutput($sformatf("s%0d_stall", n_sh[k]), DW'(gs), DW'(needNow() && ph[k] != 2));
      checkOutput($sformatf("s%0d_valid", n_sh[k]), DW'(gv), DW'(ph[k] == 2));
      if (ph[k] == 2)   checkOutput($sformatf("s%0d_data", n_sh[k]), gd, res[k]);
      else if (zero[k]) checkOutput($sformatf("s%0d_zero", n_sh[k]), gd, '0);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rv, input logic [0:0] sel,
                               input logic [3*DW-1:0] sh, input logic ack, input logic kl);
    @(negedge clk);
    reset = rst; req_valid = rv; src_a_sel = sel; shares = sh; ex_ack = ack; kill = kl;
    #1;
    checkAll();
    @(posedge clk);
    modelStep();
  endtask

  task automatic drain();
    repeat (3) applyStimulus(1'b0, 1'b0, RS1, '0, 1'b1, 1'b0);
  endtask

  logic [3*DW-1:0] s0, s1, s2, sr;

  initial begin
    s0 = {32'h0000_0000, 32'h0F0F_1234, 32'hA5A5_0000};
    s1 = {32'h0000_0000, 32'h0000_0002, 32'h0000_0001};
    s2 = {32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    reset = 1'b1; req_valid = 1'b0; src_a_sel = RS1; shares = '0; ex_ack = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    modelStep();

    // Reset state, then the basic merge held in DONE without ack
    applyStimulus(1'b1, 1'b1, RS1, s0, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b1, RS1, s0, 1'b0, 1'b0);
    // Ack with a new request pending in the same cycle, then back-to-back merge
    applyStimulus(1'b0, 1'b1, RS1, s0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, RS1, s1, 1'b0, 1'b0);
    drain();

    // PC-selected operand: never stalls, never merges
    repeat (4) applyStimulus(1'b0, 1'b1, PC, s0, 1'b0, 1'b0);

    // Live shares change after capture
    applyStimulus(1'b0, 1'b1, RS1, s1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, RS1, s2, 1'b0, 1'b0);
    drain();

    // Kill mid-accumulation, idle cycle, fresh request
    applyStimulus(1'b0, 1'b1, RS1, s0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, RS1, s0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, RS1, s0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, RS1, s1, 1'b0, 1'b0);
    drain();

    // Reset in cycle 1 of a merge
    applyStimulus(1'b0, 1'b1, RS1, s0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, RS1, s0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, RS1, s0, 1'b0, 1'b0);

    // Kill and ack together while holding a result
    repeat (4) applyStimulus(1'b0, 1'b1, RS1, s0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, RS1, s0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, RS1, s0, 1'b0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      sr = {$urandom(), $urandom(), $urandom()};
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0) ? PC : RS1, sr,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
